// File: rtl/bist_ctrl.sv
// Memory/logic BIST sequencer: seeds the pattern LFSR, runs N patterns, compacts CUT responses in a MISR
// and compares the signature. Define BIST_CAPTURE_PIPE2_EN for a 2-cycle capture latency (registered CUT).
module bist_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_patterns,
    input  logic [15:0] golden_sig,
    input  logic [15:0] cut_resp,
    output logic        lfsr_reset,
    output logic        lfsr_enable,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] pattern_cnt,
    output logic [2:0]  state_dbg
);

`ifdef BIST_CAPTURE_PIPE2_EN
    localparam int CAP_LAT = 2;
`else
    localparam int CAP_LAT = 1;
`endif
    localparam logic [1:0] FLUSH_LAST = 2'(CAP_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state;
    logic [15:0]         n_q;
    logic [15:0]         golden_q;
    logic [15:0]         misr;
    logic [15:0]         cnt;
    logic [1:0]          flush_cnt;
    logic [CAP_LAT-1:0]  cap_pipe;
    logic                cap_valid;

    // Handshake: start is a level sampled only in IDLE; abort is sampled every busy cycle and wins over everything.
    assign lfsr_reset  = (state == S_SEED);
    assign lfsr_enable = (state == S_RUN);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign signature   = misr;
    assign pattern_cnt = cnt;
    assign state_dbg   = state;
    assign cap_valid   = cap_pipe[CAP_LAT-1];

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
        logic [15:0] nx;
        nx      = {m[14:0], m[15]};
        nx[6:4] = m[5:3] ^ {3{m[15]}};
        return nx ^ d;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            n_q       <= '0;
            golden_q  <= '0;
            misr      <= '0;
            cnt       <= '0;
            flush_cnt <= '0;
            cap_pipe  <= '0;
            pass      <= 1'b0;
        end else begin
            // Abort flushes in-flight captures so nothing lands in the MISR after the run is dropped.
`ifdef BIST_CAPTURE_PIPE2_EN
            cap_pipe <= abort ? 2'b00 : {cap_pipe[0], lfsr_enable};
`else
            cap_pipe <= abort ? 1'b0 : lfsr_enable;
`endif
            if (cap_valid)
                misr <= misr_step(misr, cut_resp);

            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state    <= S_SEED;
                        n_q      <= num_patterns;
                        golden_q <= golden_sig;
                        misr     <= '0;
                        cnt      <= '0;
                        pass     <= 1'b0;
                    end
                end
                S_SEED: begin
                    flush_cnt <= '0;
                    if (abort)
                        state <= S_IDLE;
                    else
                        state <= (n_q != 16'd0) ? S_RUN : S_FLUSH;
                end
                S_RUN: begin
                    cnt <= cnt + 16'd1;
                    if (abort)
                        state <= S_IDLE;
                    else if (({1'b0, cnt} + 17'd1) == {1'b0, n_q})
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (abort)
                        state <= S_IDLE;
                    else if (flush_cnt == FLUSH_LAST)
                        state <= S_COMPARE;
                    else
                        flush_cnt <= flush_cnt + 2'd1;
                end
                S_COMPARE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        pass  <= (misr == golden_q);
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bist_ctrl.md
BIST_CTRL -- requirements
Module: bist_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  one-cycle request to begin a BIST run; sampled only in IDLE.
REQ-005 Port: abort  input  1  terminates an active run; sampled in every non-IDLE state.
REQ-006 Port: num_patterns  input  16  number of LFSR patterns to apply; latched at start.
REQ-007 Port: golden_sig  input  16  expected signature; latched at start.
REQ-008 Port: cut_resp  input  16  circuit-under-test response to the pattern applied in the previous cycle.
REQ-009 Port: lfsr_reset  output  1  synchronous active-high seed command to the 16-bit pattern LFSR, which loads 0xFFFF.
REQ-010 Port: lfsr_enable  output  1  advance command to the pattern LFSR.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  one-cycle pulse when a run completes; never asserted on abort.
REQ-013 Port: pass  output  1  signature == golden_sig for the last completed run; held until the next start.
REQ-014 Port: signature  output  16  current MISR contents.
REQ-015 Port: pattern_cnt  output  16  patterns applied in the current or last run.

Function
REQ-016 The FSM SHALL have the states IDLE, SEED, RUN, FLUSH, COMPARE and DONE; lfsr_reset=1 only in SEED, lfsr_enable=1 only in RUN, and both outputs are decoded from the state register.
REQ-017 IDLE->SEED occurs when start=1 and abort=0; in SEED, misr and pattern_cnt are cleared to 0, pass is cleared to 0, and num_patterns/golden_sig are latched.
REQ-018 SEED->RUN occurs if the latched num_patterns != 0; otherwise SEED->FLUSH.
REQ-019 In RUN, pattern_cnt increments once per cycle, and RUN->FLUSH occurs in the cycle where pattern_cnt+1 == the latched num_patterns, so RUN lasts exactly num_patterns cycles.
REQ-020 A capture-valid flag SHALL be lfsr_enable delayed by the capture latency (1 cycle by default); misr updates only when the flag is 1.
REQ-021 The MISR update SHALL be Galois with feedback f=misr[15]: new[0]=f; new[i]=misr[i-1] for i=1..3 and 7..15; new[i]=misr[i-1]^f for i=4,5,6; the result is XORed with cut_resp.
REQ-022 FLUSH lasts the capture latency in cycles, then FLUSH->COMPARE.
REQ-023 COMPARE sets pass <= (misr == latched golden_sig), then COMPARE->DONE.
REQ-024 DONE asserts done=1 for one cycle, then DONE->IDLE.
REQ-025 Total latency from start sampled in cycle 0 to done is cycle N+4 (default latency, N=num_patterns).
REQ-026 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with no done, pass left at 0, and misr/pattern_cnt frozen.
REQ-027 start while busy SHALL be ignored; start and abort together in IDLE SHALL be ignored.
REQ-028 pattern_cnt SHALL NOT wrap: num_patterns=0xFFFF runs exactly 65535 cycles.

Reset
REQ-029 Asserting reset_n=0 SHALL immediately force the state to IDLE and lfsr_reset=0, lfsr_enable=0, busy=0, done=0, pass=0, signature=0x0000, pattern_cnt=0x0000, and clear the capture-valid pipeline.
REQ-030 Reset mid-run SHALL discard the run; the first edge after release is in IDLE.

Configuration
REQ-031 When the macro BIST_CAPTURE_PIPE2_EN is defined, the capture latency SHALL be 2 cycles (valid delayed 2, FLUSH 2 cycles, done at N+5) to support a registered CUT; when it is undefined, the latency SHALL be 1.

Verification
REQ-032 Test: reset_n=0 mid-RUN -> all outputs at reset values immediately; IDLE after release.
REQ-033 Test: num_patterns=1, cut_resp=0x0001, golden=0x0001 -> lfsr_enable high 1 cycle, signature=0x0001, done at cycle 5, pass=1.
REQ-034 Test: num_patterns=2, cut_resp=0x8000 constant, golden=0x8071 -> signature=0x8071, pass=1; with golden=0x8070 -> pass=0.
REQ-035 Test: num_patterns=0 -> no lfsr_enable, signature=0x0000, done at cycle 4.
REQ-036 Test: abort in the 3rd RUN cycle of a 10-pattern run -> IDLE next cycle, pattern_cnt=3, no done, pass=0.
REQ-037 Test: start pulsed during RUN -> ignored; the run completes normally with a single done.
